// File: rtl/rx_pixel_assembler.sv
// rtl/rx_pixel_assembler.sv - UART byte stream to 24-bit RGB frame RAM writes
//
// Purpose: waits for a start-of-frame byte, packs each R,G,B byte triplet into
// one pixel and writes it to a raster-order address. Pulses frame_done after the
// last pixel of the frame; aborts a frame whose inter-byte gap exceeds TIMEOUT_CYC.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high
//   rx_data      received byte, valid when rx_done=1
//   rx_done      1-cycle strobe marking a new byte
//   pixel_we     1-cycle frame RAM write strobe
//   pixel_data   {R,G,B}, first byte of the triplet in [23:16]
//   pixel_addr   raster index of the current write
//   frame_done   1-cycle pulse after the full frame has been written
//   busy         high while a frame is being received
//   timeout_err  1-cycle pulse when a frame is aborted by the byte-gap timeout

module rx_pixel_assembler #(
   parameter int         IMG_W       = 240,
   parameter int         IMG_H       = 176,
   parameter logic [7:0] SOF_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CYC = 100000
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [7:0]                                 rx_data,
   input  logic                                       rx_done,
   output logic                                       pixel_we,
   output logic [23:0]                                pixel_data,
   output logic [((IMG_W*IMG_H) > 1 ? $clog2(IMG_W*IMG_H) : 1)-1:0] pixel_addr,
   output logic                                       frame_done,
   output logic                                       busy,
   output logic                                       timeout_err
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int GW   = $clog2(TIMEOUT_CYC);

   localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [AW-1:0] pix_cnt_q, pix_cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    r_q, r_d;
   logic [7:0]    g_q, g_d;
   logic          pixel_we_q, pixel_we_d;
   logic [23:0]   pixel_data_q, pixel_data_d;
   logic [AW-1:0] pixel_addr_q, pixel_addr_d;
   logic          frame_done_q, frame_done_d;
   logic          timeout_err_q, timeout_err_d;

   always_comb begin
      state_d       = state_q;
      byte_idx_d    = byte_idx_q;
      pix_cnt_d     = pix_cnt_q;
      gap_d         = gap_q;
      r_d           = r_q;
      g_d           = g_q;
      pixel_we_d    = 1'b0;
      pixel_data_d  = pixel_data_q;
      pixel_addr_d  = pixel_addr_q;
      frame_done_d  = 1'b0;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_done && (rx_data == SOF_BYTE)) begin
               state_d    = ST_RECV;
               byte_idx_d = 2'd0;
               pix_cnt_d  = '0;
               gap_d      = '0;
            end
         end

         ST_RECV: begin
            // A byte arriving on the timeout cycle takes priority over the abort.
            if (rx_done) begin
               gap_d = '0;
               case (byte_idx_q)
                  2'd0: begin
                     r_d        = rx_data;
                     byte_idx_d = 2'd1;
                  end
                  2'd1: begin
                     g_d        = rx_data;
                     byte_idx_d = 2'd2;
                  end
                  default: begin
                     pixel_we_d   = 1'b1;
                     pixel_data_d = {r_q, g_q, rx_data};
                     pixel_addr_d = pix_cnt_q;
                     byte_idx_d   = 2'd0;
                     // Clear rather than increment on the last pixel so the
                     // counter never overflows for power-of-two frame sizes.
                     if (pix_cnt_q == LAST_PIX) begin
                        pix_cnt_d = '0;
                        state_d   = ST_DONE;
                     end else begin
                        pix_cnt_d = pix_cnt_q + AW'(1);
                     end
                  end
               endcase
            end else if (gap_q == GAP_MAX) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
               byte_idx_d    = 2'd0;
               pix_cnt_d     = '0;
               gap_d         = '0;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         ST_DONE: begin
            // Any byte arriving in this cycle is dropped, including a SOF.
            frame_done_d = 1'b1;
            pix_cnt_d    = '0;
            state_d      = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         byte_idx_q    <= 2'd0;
         pix_cnt_q     <= '0;
         gap_q         <= '0;
         r_q           <= 8'd0;
         g_q           <= 8'd0;
         pixel_we_q    <= 1'b0;
         pixel_data_q  <= 24'd0;
         pixel_addr_q  <= '0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_idx_q    <= byte_idx_d;
         pix_cnt_q     <= pix_cnt_d;
         gap_q         <= gap_d;
         r_q           <= r_d;
         g_q           <= g_d;
         pixel_we_q    <= pixel_we_d;
         pixel_data_q  <= pixel_data_d;
         pixel_addr_q  <= pixel_addr_d;
         frame_done_q  <= frame_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign pixel_we    = pixel_we_q;
   assign pixel_data  = pixel_data_q;
   assign pixel_addr  = pixel_addr_q;
   assign frame_done  = frame_done_q;
   assign timeout_err = timeout_err_q;
   assign busy        = (state_q == ST_RECV);

endmodule
